ram_arbiter: RTL and testbench

- Shares one single-port 8-bit x 256 synchronous RAM (address/data/w_r/cs/out interface) between two requesters.
- Each requester issues single-beat read or write transactions through a valid/ready handshake and receives a one-cycle response pulse.
- A round-robin arbiter serialises the accesses and drives the RAM control pins. Only this block drives the RAM.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arbiter_rr_arb2.sv | 41 ++++
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
//   state_e    : arbiter FSM states
//   ADDR_W_DEF : default RAM address width
//   DATA_W_DEF : default RAM data width
//   WR / RD    : encodings of the RAM w_r pin
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector, bit i = requester i
//   en         : grant is consumed this cycle; updates the last-grant record
//   gnt_c      : one-hot grant (combinational)
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt_c
);

    logic last_q;
    logic last_d;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        gnt_c[0] = req[0] & (~req[1] | last_q);
        gnt_c[1] = req[1] & (~req[0] | ~last_q);
    end

    always_comb begin
        last_d = last_q;
        if (en && (|req)) begin
            last_d = gnt_c[1];
        end
    end

    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises single-beat reads/writes from two requesters onto one
// single-port synchronous RAM.
//   clk, rst_n          : clock, synchronous active-low reset
//   reqX_valid/wr/addr/wdata, reqX_ready : request handshake (ready is combinational)
//   rspX_valid, rspX_rdata              : one-cycle completion pulse and read data
//   ram_address/data/w_r/cs             : RAM control (registered)
//   ram_out                             : RAM read data
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_w_r,
    output logic              ram_cs,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int unsigned CNT_W = 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gid_q, gid_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_w_r_q, ram_w_r_d;
    logic              ram_cs_q, ram_cs_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic [1:0] gnt_c;
    logic       idle_c;

    assign idle_c = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (idle_c),
        .gnt_c (gnt_c)
    );

    assign req0_ready  = idle_c & gnt_c[0];
    assign req1_ready  = idle_c & gnt_c[1];

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_w_r     = ram_w_r_q;
    assign ram_cs      = ram_cs_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_rdata  = rsp0_rdata_q;
    assign rsp1_rdata  = rsp1_rdata_q;

    // Next-state and registered-output logic; RAM pins are loaded on accept
    // so that cs and the latched request appear together in ISSUE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gid_d         = gid_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_w_r_d     = ram_w_r_q;
        ram_cs_d      = 1'b0;
        rsp0_valid_d  = 1'b0;
        rsp1_valid_d  = 1'b0;
        rsp0_rdata_d  = rsp0_rdata_q;
        rsp1_rdata_d  = rsp1_rdata_q;

        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    gid_d         = gnt_c[1];
                    ram_w_r_d     = gnt_c[1] ? req1_wr    : req0_wr;
                    ram_address_d = gnt_c[1] ? req1_addr  : req0_addr;
                    ram_data_d    = gnt_c[1] ? req1_wdata : req0_wdata;
                    ram_cs_d      = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_w_r_q == WR) begin
                    rsp0_valid_d = ~gid_q;
                    rsp1_valid_d = gid_q;
                    state_d      = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp0_valid_d = ~gid_q;
                    rsp1_valid_d = gid_q;
                    if (gid_q) begin
                        rsp1_rdata_d = ram_out;
                    end else begin
                        rsp0_rdata_d = ram_out;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gid_q         <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_w_r_q     <= 1'b0;
            ram_cs_q      <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_rdata_q  <= '0;
            rsp1_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gid_q         <= gid_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_w_r_q     <= ram_w_r_d;
            ram_cs_q      <= ram_cs_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_rdata_q  <= rsp0_rdata_d;
            rsp1_rdata_q  <= rsp1_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter with a behavioural 8x256 synchronous RAM (latency 1).
module tb_ram_arbiter;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned RDL = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_wr, req0_ready, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_wr, req1_ready, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_w_r, ram_cs;
    logic [DW-1:0] ram_out;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_w_r(ram_w_r),
        .ram_cs(ram_cs), .ram_out(ram_out)
    );

    // RAM model: one-edge read latency.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_w_r) mem[ram_address] <= ram_data;
            else         ram_out <= mem[ram_address];
        end
    end

    typedef struct {
        int          p;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } op_t;

    typedef struct {
        int          cyc;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q0[$], exp_q1[$];
    op_t  ops0[$], ops1[$];
    int   grant_log[$];

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       last_g;
    logic [7:0] last_rd [2];
    int         idle_at;
    int         acc_cyc;
    op_t        acc_op;
    logic       cs_pending = 1'b0;
    exp_t       e0, e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response and RAM-pin monitor.
    always @(negedge clk) begin
        if (rsp0_valid === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp0_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e0 = exp_q0.pop_front();
                chk("rsp0_cycle", cyc, e0.cyc);
                chk("rsp0_rdata", rsp0_rdata, e0.rdata);
            end
        end
        if (rsp1_valid === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp1_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e1 = exp_q1.pop_front();
                chk("rsp1_cycle", cyc, e1.cyc);
                chk("rsp1_rdata", rsp1_rdata, e1.rdata);
            end
        end
        if (cs_pending && cyc == acc_cyc + 1) begin
            cs_pending = 1'b0;
            chk("issue_cs", ram_cs, 1);
            chk("issue_w_r", ram_w_r, acc_op.wr);
            chk("issue_addr", ram_address, acc_op.addr);
            if (acc_op.wr) chk("issue_data", ram_data, acc_op.wdata);
        end else if (ram_cs === 1'b1) begin
            checks++; errors++;
            $display("FAIL ram_cs_stray: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    always @(negedge clk) begin
        #2;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
            checks++; errors++;
            $display("FAIL ready_exclusive: got both ready expected at most one (cycle %0d)", cyc);
        end
    end

    // Bookkeeping for an accepted request in the current cycle.
    task automatic note_accept(input op_t op);
        exp_t e;
        e.cyc = cyc + (op.wr ? 2 : 2 + RDL);
        if (!op.wr) last_rd[op.p] = op.exp_rd;
        e.rdata = last_rd[op.p];
        if (op.p == 0) exp_q0.push_back(e);
        else           exp_q1.push_back(e);
        last_g     = (op.p == 1);
        idle_at    = e.cyc + 1;
        acc_cyc    = cyc;
        acc_op     = op;
        cs_pending = 1'b1;
        grant_log.push_back(op.p);
    endtask

    task automatic drive(input int p, input logic v, input op_t op);
        if (p == 0) begin
            req0_valid = v; req0_wr = op.wr; req0_addr = op.addr; req0_wdata = op.wdata;
        end else begin
            req1_valid = v; req1_wr = op.wr; req1_addr = op.addr; req1_wdata = op.wdata;
        end
    endtask

    // Present ops0/ops1 concurrently, each requester back-to-back.
    task automatic run();
        logic v [2];
        op_t  cur [2];
        int   budget;
        int   g, exp_g;
        v[0] = 1'b0; v[1] = 1'b0;
        budget = 400;
        while ((ops0.size() > 0 || ops1.size() > 0 || v[0] || v[1]) && budget > 0) begin
            @(negedge clk);
            if (!v[0] && ops0.size() > 0) begin cur[0] = ops0.pop_front(); v[0] = 1'b1; end
            if (!v[1] && ops1.size() > 0) begin cur[1] = ops1.pop_front(); v[1] = 1'b1; end
            drive(0, v[0], cur[0]);
            drive(1, v[1], cur[1]);
            #1;
            if (req0_ready || req1_ready) begin
                g     = req0_ready ? 0 : 1;
                exp_g = (v[0] && v[1]) ? (last_g ? 0 : 1) : (v[0] ? 0 : 1);
                chk("grant_id", g, exp_g);
                note_accept(cur[g]);
                v[g] = 1'b0;
            end else if ((v[0] || v[1]) && cyc >= idle_at) begin
                checks++; errors++;
                $display("FAIL grant_missing: got no ready expected a grant (cycle %0d)", cyc);
            end
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL run_timeout: got no progress expected all ops granted");
            ops0.delete(); ops1.delete();
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 50 && (exp_q0.size() > 0 || exp_q1.size() > 0); k++) @(negedge clk);
        if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    task automatic reset_model();
        exp_q0.delete(); exp_q1.delete();
        last_g = 1'b1; last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        idle_at = 0; cs_pending = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {ram_cs, ram_w_r, rsp0_valid, rsp1_valid}, 0);
        chk({tag, "_addr"}, ram_address, 0);
        chk({tag, "_data"}, ram_data, 0);
        chk({tag, "_rdata0"}, rsp0_rdata, 0);
        chk({tag, "_rdata1"}, rsp1_rdata, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        reset_model();
        rst_n = 1'b1;
    endtask

    function automatic op_t mk(input int p, input logic wr, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] x);
        op_t o;
        o.p = p; o.wr = wr; o.addr = a; o.wdata = d; o.exp_rd = x;
        return o;
    endfunction

    op_t vec [6];
    op_t op;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_out = 8'h00;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
        reset_model();

        apply_reset();

        // Single-requester vectors, including top/bottom address.
        vec[0] = mk(0, 1'b1, 8'h00, 8'hCC, 8'h00);
        vec[1] = mk(0, 1'b0, 8'h00, 8'h00, 8'hCC);
        vec[2] = mk(1, 1'b1, 8'hFF, 8'h5A, 8'h00);
        vec[3] = mk(1, 1'b0, 8'hFF, 8'h00, 8'h5A);
        vec[4] = mk(1, 1'b0, 8'h00, 8'h00, 8'hCC);
        vec[5] = mk(0, 1'b0, 8'hFF, 8'h00, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            if (vec[i].p == 0) ops0.push_back(vec[i]);
            else               ops1.push_back(vec[i]);
            run();
        end

        // Simultaneous writes right after reset, then simultaneous read-back.
        apply_reset();
        grant_log.delete();
        ops0.push_back(mk(0, 1'b1, 8'h01, 8'hFC, 8'h00));
        ops1.push_back(mk(1, 1'b1, 8'h02, 8'h33, 8'h00));
        run();
        chk("first_grant", grant_log.size() > 0 ? grant_log[0] : 9, 0);
        ops0.push_back(mk(0, 1'b0, 8'h01, 8'h00, 8'hFC));
        ops1.push_back(mk(1, 1'b0, 8'h02, 8'h00, 8'h33));
        run();

        // Continuous contention: strict alternation.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            ops0.push_back(mk(0, 1'b0, 8'h01, 8'h00, 8'hFC));
            ops1.push_back(mk(1, 1'b0, 8'h01, 8'h00, 8'hFC));
        end
        run();
        chk("alt_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) chk("alt_order", grant_log[i], i % 2);

        // Reset while a req1 read sits in WAIT.
        @(negedge clk);
        op = mk(1, 1'b0, 8'h02, 8'h00, 8'h33);
        drive(1, 1'b1, op);
        #1;
        chk("rst_test_ready1", req1_ready, 1);
        if (req1_ready) note_accept(op);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("abort");
        reset_model();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ops1.push_back(mk(1, 1'b0, 8'h02, 8'h00, 8'h33));
        run();

        // req1 withdraws while req0 is being served.
        @(negedge clk);
        op = mk(0, 1'b1, 8'h10, 8'h77, 8'h00);
        drive(0, 1'b1, op);
        #1;
        chk("wd_ready0", req0_ready, 1);
        if (req0_ready) note_accept(op);
        @(negedge clk);
        req0_valid = 1'b0;
        drive(1, 1'b1, mk(1, 1'b0, 8'h05, 8'h00, 8'h00));
        #1;
        chk("wd_ready1_issue", req1_ready, 0);
        @(negedge clk);
        #1;
        chk("wd_ready1_resp", req1_ready, 0);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("wd_cs_idle", ram_cs, 0);
        repeat (4) @(negedge clk);
        chk("wd_no_pending", exp_q0.size() + exp_q1.size(), 0);
        ops0.push_back(mk(0, 1'b0, 8'h10, 8'h00, 8'h77));
        run();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule
